// File: rtl/fir_mac_seq.sv
// fir_mac_seq: sequential FIR MAC stage; one shared multiplier walks TAPS taps per accepted sample.
// Optional build macro FIR_MAC_SAT_EN: out_data = sat_DW(acc >>> (CW-1)), sign-extended to OW.
module fir_mac_seq #(
    parameter int TAPS = 4,
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int OW   = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TAPS*CW-1:0]   coef,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OW-1:0]        out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PW = DW + CW;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t                 state_reg;
    logic signed [DW-1:0]   tap_reg  [TAPS];
    logic signed [CW-1:0]   creg_reg [TAPS];
    logic signed [CW-1:0]   coef_word [TAPS];
    logic signed [OW-1:0]   acc_reg;
    logic signed [OW-1:0]   acc_next;
    logic signed [OW-1:0]   out_data_reg;
    logic signed [OW-1:0]   result;
    logic [IW-1:0]          idx_reg;
    logic signed [PW-1:0]   prod;

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef
            assign coef_word[gi] = coef[gi*CW +: CW];
        end
    endgenerate

    assign prod     = tap_reg[idx_reg] * creg_reg[idx_reg];
    assign acc_next = acc_reg + {{(OW-PW){prod[PW-1]}}, prod};

`ifdef FIR_MAC_SAT_EN
    localparam logic signed [OW-1:0] SAT_MAX = OW'((1 << (DW-1)) - 1);
    localparam logic signed [OW-1:0] SAT_MIN = ~SAT_MAX;
    logic signed [OW-1:0] scaled;

    // Coefficients are Q1.(CW-1): drop the fractional bits before clamping.
    always_comb begin
        scaled = acc_next >>> (CW-1);
        result = scaled;
        if (scaled > SAT_MAX) begin
            result = SAT_MAX;
        end else if (scaled < SAT_MIN) begin
            result = SAT_MIN;
        end
    end
`else
    assign result = acc_next;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            idx_reg      <= '0;
            out_data_reg <= '0;
            for (int k = 0; k < TAPS; k++) begin
                tap_reg[k]  <= '0;
                creg_reg[k] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        tap_reg[0] <= in_data;
                        for (int k = 1; k < TAPS; k++) begin
                            tap_reg[k] <= tap_reg[k-1];
                        end
                        for (int k = 0; k < TAPS; k++) begin
                            creg_reg[k] <= coef_word[k];
                        end
                        acc_reg   <= '0;
                        idx_reg   <= '0;
                        state_reg <= MAC;
                    end
                end
                MAC: begin
                    acc_reg <= acc_next;
                    idx_reg <= idx_reg + 1'b1;
                    if (idx_reg == IW'(TAPS-1)) begin
                        out_data_reg <= result;
                        state_reg    <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == OUT);
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Randomized bench for fir_mac_seq against a sum-of-products model over the sample history.
module tb_fir_mac_seq;
    localparam int TAPS = 4;
    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int OW   = 18;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [TAPS*CW-1:0]   coef = '0;
    logic [DW-1:0]        in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [OW-1:0]        out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_out = 0;
    int bp_mode = 0;
    int hist [TAPS];
    int exp_q [$];
    int acc_cyc_q [$];
    int out_log [$];

    fir_mac_seq #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW)) dut (
        .clk(clk), .rst(rst), .coef(coef), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // out_ready owner: 0 = always ready, 1 = random stalls, 2 = held low
    always @(posedge clk) begin
        #1;
        if (bp_mode == 0) out_ready = 1'b1;
        else if (bp_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        else out_ready = 1'b0;
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int model_y(input logic [TAPS*CW-1:0] c);
        int s;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += $signed(c[k*CW +: CW]) * hist[k];
`ifdef FIR_MAC_SAT_EN
        s = s >>> (CW-1);
        if (s > (1 << (DW-1)) - 1) s = (1 << (DW-1)) - 1;
        if (s < -(1 << (DW-1))) s = -(1 << (DW-1));
`endif
        return s;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < TAPS; k++) hist[k] = 0;
        exp_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic send(input logic [DW-1:0] s, input logic [TAPS*CW-1:0] c, output int acc_at);
        int t;
        t = 0;
        acc_at = -1;
        @(negedge clk);
        in_data = s;
        coef = c;
        in_valid = 1'b1;
        while (!in_ready) begin
            @(negedge clk);
            t++;
            if (t > 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 100 cycles");
                in_valid = 1'b0;
                return;
            end
        end
        for (int k = TAPS-1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = $signed(s);
        exp_q.push_back(model_y(c));
        acc_cyc_q.push_back(cyc);
        acc_at = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_data = DW'($urandom);
        coef = $urandom;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            t++;
            if (t > 300) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
                exp_q.delete();
                acc_cyc_q.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send_list(input logic [TAPS*CW-1:0] c, input int v0, input int v1,
                             input int v2, input int v3);
        int a;
        int vals [4];
        vals = '{v0, v1, v2, v3};
        out_log.delete();
        for (int i = 0; i < 4; i++) send(DW'(vals[i]), c, a);
        drain();
    endtask

    task automatic pin_log(input string name, input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        check({name, "_count"}, out_log.size(), 4);
        if (out_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check(name, out_log[i], e[i]);
        end
    endtask

    // Compare process: every cycle out_valid is high, out_data must equal the oldest expected result.
    initial begin : cmp
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_out: out_valid=1 with data %0d, expected no result pending",
                             $signed(out_data));
                end else begin
                    check("out_data", $signed(out_data), exp_q[0]);
                    check("in_ready_in_out", int'(in_ready), 0);
                    if (!seen) begin
                        check("latency", cyc - acc_cyc_q[0], TAPS + 1);
                        seen = 1'b1;
                    end
                    if (out_ready) begin
                        n_out++;
                        out_log.push_back($signed(out_data));
                        $display("out %0d: data=%0d", n_out, $signed(out_data));
                        void'(exp_q.pop_front());
                        void'(acc_cyc_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : drv
        int a;
        int prev;
        int held;
        model_clear();
        @(negedge clk);
        #1;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", $signed(out_data), 0);
        @(negedge clk);
        rst = 1'b1;

`ifdef FIR_MAC_SAT_EN
        send_list(32'h7f7f7f7f, 127, 127, 127, 127);
        check("sat_pos_last", out_log.size() == 4 ? out_log[3] : -9999, 127);
        send_list(32'h7f7f7f7f, -128, -128, -128, -128);
        check("sat_neg_last", out_log.size() == 4 ? out_log[3] : -9999, -128);
`else
        send_list(32'h04030201, 1, 0, 0, 0);
        pin_log("impulse", 1, 2, 3, 4);
        send_list(32'h04030201, 10, 10, 10, 10);
        pin_log("step", 10, 30, 60, 100);
        send_list(32'h80808080, -128, -128, -128, -128);
        check("extreme_last", out_log.size() == 4 ? out_log[3] : -9999, 65536);
        out_log.delete();
        send(8'h80, 32'h7f7f7f7f, a);
        drain();
        check("extreme_neg", out_log.size() == 1 ? out_log[0] : -9999, -16256 * TAPS);
`endif

        // Throughput: back-to-back accepts with out_ready high are TAPS+2 cycles apart.
        send(DW'($urandom), $urandom, prev);
        for (int i = 0; i < 3; i++) begin
            send(DW'($urandom), $urandom, a);
            check("accept_spacing", a - prev, TAPS + 2);
            prev = a;
        end
        drain();

        // Backpressure: hold OUT, pulse in_valid, release.
        bp_mode = 2;
        send(DW'($urandom), $urandom, a);
        while (!out_valid) @(negedge clk);
        held = $signed(out_data);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin in_valid = 1'b1; in_data = DW'($urandom); end
            if (i == 3) in_valid = 1'b0;
            #1;
            check("bp_hold_data", $signed(out_data), held);
            check("bp_out_valid", int'(out_valid), 1);
        end
        bp_mode = 0;
        @(posedge clk);
        #2;
        @(posedge clk);
        #1;
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_release_ready", int'(in_ready), 1);
        drain();

        // Reset mid-MAC discards the in-flight 5 and all history.
        send(8'd5, 32'h04030201, a);
        pulse_reset();
        send_list(32'h04030201, 1, 0, 0, 0);
`ifndef FIR_MAC_SAT_EN
        pin_log("post_reset_impulse", 1, 2, 3, 4);
`endif

        // Randomized traffic with random stalls and idle gaps.
        bp_mode = 1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(DW'($urandom), $urandom, a);
        end
        bp_mode = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
